// File: rtl/phase3b_pkg.sv
// Shared types and constants for the phase-3b derotation stream.
package phase3b_pkg;

  localparam int KEY_W         = 3;
  localparam int BITSTREAM_DEF = 64;

  typedef logic [KEY_W-1:0] phase3b_key_t;

endpackage

// File: rtl/phase3b_rotr_stage.sv
// Combinational right-rotate of a word by a fixed amount, applied only when en is set.
module phase3b_rotr_stage
  import phase3b_pkg::*;
#(
  parameter int W   = BITSTREAM_DEF,
  parameter int AMT = 1
) (
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  // dout[i] = din[(i + AMT) mod W] when enabled
  always_comb begin
    if (en) begin
      dout = {din[AMT-1:0], din[W-1:AMT]};
    end else begin
      dout = din;
    end
  end

endmodule

// File: rtl/phase_3b_derotate_stream.sv
// Undoes the phase-3b left rotation through a 2-stage elastic pipeline and counts words/frames.
// Optional build macro PHASE3B_DEROT_AUTOKEY_EN replaces the per-word k port with a self-advancing key register.
module phase_3b_derotate_stream
  import phase3b_pkg::*;
#(
  parameter int BITSTREAM = BITSTREAM_DEF,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BITSTREAM-1:0] in_bits,
  input  logic [KEY_W-1:0]     k,
`ifdef PHASE3B_DEROT_AUTOKEY_EN
  input  logic [KEY_W-1:0]     key_seed,
`endif
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BITSTREAM-1:0] out_bits,
  output logic                 out_last,
  output logic [CNT_W-1:0]     word_cnt,
  output logic [CNT_W-1:0]     frame_cnt,
  output logic                 frame_done
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic                 ready1;
  logic                 ready2;
  logic                 in_hs;
  logic                 out_hs;
  phase3b_key_t         key_s;
  logic [BITSTREAM-1:0] rot4_s;
  logic [BITSTREAM-1:0] rot42_s;
  logic [BITSTREAM-1:0] rot1_s;

  logic [BITSTREAM-1:0] d1_r;
  logic                 k0_r;
  logic                 last1_r;
  logic                 v1_r;
  logic [BITSTREAM-1:0] d2_r;
  logic                 last2_r;
  logic                 v2_r;
  logic [CNT_W-1:0]     word_cnt_r;
  logic [CNT_W-1:0]     frame_cnt_r;
  logic                 frame_done_r;

  assign ready2   = !v2_r || out_ready;
  assign ready1   = !v1_r || ready2;
  assign in_hs    = in_valid && ready1;
  assign out_hs   = v2_r && out_ready;
  assign in_ready = ready1;

`ifdef PHASE3B_DEROT_AUTOKEY_EN
  phase3b_key_t key_r;
  logic         unused_k;

  assign unused_k = ^k;
  assign key_s    = key_r;

  // Key advances per accepted word and restarts from the seed at each frame boundary
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_r <= key_seed;
    end else if (in_hs) begin
      if (in_last) begin
        key_r <= key_seed;
      end else begin
        key_r <= key_r + phase3b_key_t'(1);
      end
    end else begin
      key_r <= key_r;
    end
  end
`else
  assign key_s = k;
`endif

  phase3b_rotr_stage #(.W(BITSTREAM), .AMT(4)) u_rot4 (
    .en   (key_s[2]),
    .din  (in_bits),
    .dout (rot4_s)
  );

  phase3b_rotr_stage #(.W(BITSTREAM), .AMT(2)) u_rot2 (
    .en   (key_s[1]),
    .din  (rot4_s),
    .dout (rot42_s)
  );

  // The k[0] rotation is deferred to stage 2 to split the mux depth across stages
  phase3b_rotr_stage #(.W(BITSTREAM), .AMT(1)) u_rot1 (
    .en   (k0_r),
    .din  (d1_r),
    .dout (rot1_s)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d1_r    <= '0;
      k0_r    <= 1'b0;
      last1_r <= 1'b0;
      v1_r    <= 1'b0;
      d2_r    <= '0;
      last2_r <= 1'b0;
      v2_r    <= 1'b0;
    end else begin
      if (ready1) begin
        v1_r <= in_valid;
        if (in_valid) begin
          d1_r    <= rot42_s;
          k0_r    <= key_s[0];
          last1_r <= in_last;
        end
      end
      if (ready2) begin
        v2_r <= v1_r;
        if (v1_r) begin
          d2_r    <= rot1_s;
          last2_r <= last1_r;
        end
      end
    end
  end

  // Delivery counters; frame_done pulses the cycle after a last-word handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_cnt_r   <= '0;
      frame_cnt_r  <= '0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= out_hs && last2_r;
      if (out_hs) begin
        word_cnt_r <= word_cnt_r + CNT_ONE;
        if (last2_r) begin
          frame_cnt_r <= frame_cnt_r + CNT_ONE;
        end
      end
    end
  end

  assign out_valid  = v2_r;
  assign out_bits   = d2_r;
  assign out_last   = last2_r;
  assign word_cnt   = word_cnt_r;
  assign frame_cnt  = frame_cnt_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_phase_3b_derotate_stream.sv
// Self-checking bench for phase_3b_derotate_stream: directed steps plus a randomized scoreboard run.
module tb_phase_3b_derotate_stream;

  localparam int W  = 64;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_bits;
  logic [2:0]    k;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_bits;
  logic          out_last;
  logic [CW-1:0] word_cnt;
  logic [CW-1:0] frame_cnt;
  logic          frame_done;
`ifdef PHASE3B_DEROT_AUTOKEY_EN
  logic [2:0]    key_seed = 3'd6;
  logic [2:0]    key_m;
`endif

  always #5 clk = ~clk;

  phase_3b_derotate_stream #(.BITSTREAM(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_bits    (in_bits),
    .k          (k),
`ifdef PHASE3B_DEROT_AUTOKEY_EN
    .key_seed   (key_seed),
`endif
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_bits   (out_bits),
    .out_last   (out_last),
    .word_cnt   (word_cnt),
    .frame_cnt  (frame_cnt),
    .frame_done (frame_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference: out[i] = in[(i + k) mod W]
  function automatic logic [W-1:0] derot(input logic [W-1:0] x, input int kk);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = x[(i + kk) % W];
    return r;
  endfunction

  // Forward phase-3b rotation: left rotate by k
  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input int kk);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[(i + kk) % W] = x[i];
    return r;
  endfunction

  logic [W-1:0] exp_bits_q[$];
  logic         exp_last_q[$];
  int           exp_words  = 0;
  int           exp_frames = 0;

  // Scoreboard: observe handshakes half a cycle before the edge that completes them
  initial begin
    logic [W-1:0] eb;
    logic         el;
    int           key_use;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_bits_q.delete();
        exp_last_q.delete();
        exp_words  = 0;
        exp_frames = 0;
`ifdef PHASE3B_DEROT_AUTOKEY_EN
        key_m = key_seed;
`endif
      end else begin
        if (out_valid && out_ready) begin
          if (exp_bits_q.size() == 0) begin
            check("sb_underflow", 64'(exp_bits_q.size()), 64'd1);
          end else begin
            eb = exp_bits_q.pop_front();
            el = exp_last_q.pop_front();
            check("sb_bits", out_bits, eb);
            check("sb_last", {63'd0, out_last}, {63'd0, el});
            exp_words++;
            if (el) exp_frames++;
          end
        end
        if (in_valid && in_ready) begin
`ifdef PHASE3B_DEROT_AUTOKEY_EN
          key_use = int'(key_m);
          key_m   = in_last ? key_seed : key_m + 3'd1;
`else
          key_use = int'(k);
`endif
          exp_bits_q.push_back(derot(in_bits, key_use));
          exp_last_q.push_back(in_last);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] orig;
    logic [2:0]   kk;
    logic         acc;
    int           sent;
    int           cyc;
    logic [W-1:0] r;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bits   = '0;
    k         = 3'd0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();

    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_bits", out_bits, 64'd0);
    check("rst_out_last", {63'd0, out_last}, 64'd0);
    check("rst_word_cnt", 64'(word_cnt), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("rst_frame_done", {63'd0, frame_done}, 64'd0);
    rst_n = 1'b1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);

`ifndef PHASE3B_DEROT_AUTOKEY_EN
    // Single word, k = 3
    in_valid = 1'b1; in_bits = 64'h0000_0000_0000_0001; k = 3'd3;
    step();
    in_valid = 1'b0;
    check("t1_lat1_valid", {63'd0, out_valid}, 64'd0);
    step();
    check("t1_valid", {63'd0, out_valid}, 64'd1);
    check("t1_bits", out_bits, 64'h2000_0000_0000_0000);
    step();
    check("t1_word_cnt", 64'(word_cnt), 64'd1);

    // Back-to-back words, keys 1,2,4,7
    in_valid = 1'b1; in_bits = 64'h8000_0000_0000_0000; k = 3'd1;
    step();
    k = 3'd2;
    step();
    check("t2_bits_k1", out_bits, 64'h4000_0000_0000_0000);
    k = 3'd4;
    step();
    check("t2_bits_k2", out_bits, 64'h2000_0000_0000_0000);
    k = 3'd7;
    step();
    check("t2_bits_k4", out_bits, 64'h0800_0000_0000_0000);
    in_valid = 1'b0;
    step();
    check("t2_valid_k7", {63'd0, out_valid}, 64'd1);
    check("t2_bits_k7", out_bits, 64'h0100_0000_0000_0000);
    step();
`endif

    // Downstream stall with a pending stream
    out_ready = 1'b0;
    in_valid = 1'b1; in_bits = {$urandom, $urandom}; k = 3'($urandom_range(0, 7));
    step();
    check("t3_ready_after1", {63'd0, in_ready}, 64'd1);
    in_bits = {$urandom, $urandom}; k = 3'($urandom_range(0, 7));
    step();
    in_bits = {$urandom, $urandom}; k = 3'($urandom_range(0, 7));
    for (int c = 0; c < 5; c++) begin
      check("t3_in_ready_low", {63'd0, in_ready}, 64'd0);
      check("t3_hold_valid", {63'd0, out_valid}, 64'd1);
      check("t3_hold_bits", out_bits, exp_bits_q[0]);
      check("t3_hold_last", {63'd0, out_last}, {63'd0, exp_last_q[0]});
      step();
    end
    out_ready = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      step();
      cyc++;
    end while (!acc && cyc < 20);
    check("t3_third_accepted", {63'd0, acc}, 64'd1);
    in_valid = 1'b0;
    repeat (4) step();
    check("t3_drained", 64'(exp_bits_q.size()), 64'd0);
    check("t3_word_cnt", 64'(word_cnt), 64'(exp_words[CW-1:0]));

    // Three-word frame
    in_valid = 1'b1; in_last = 1'b0; in_bits = {$urandom, $urandom};
    step();
    in_bits = {$urandom, $urandom};
    step();
    in_bits = {$urandom, $urandom}; in_last = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    check("t5_second_not_last", {63'd0, out_last}, 64'd0);
    step();
    check("t5_third_valid", {63'd0, out_valid}, 64'd1);
    check("t5_third_last", {63'd0, out_last}, 64'd1);
    check("t5_done_early", {63'd0, frame_done}, 64'd0);
    step();
    check("t5_done_pulse", {63'd0, frame_done}, 64'd1);
    check("t5_frame_cnt", 64'(frame_cnt), 64'd1);
    step();
    check("t5_done_one_cycle", {63'd0, frame_done}, 64'd0);

    // Randomized stream with random backpressure
    sent = 0; cyc = 0;
    while (sent < 10000 && cyc < 60000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && ($urandom_range(0, 3) != 0)) begin
        orig     = {$urandom, $urandom};
        kk       = 3'($urandom_range(0, 7));
        in_bits  = rotl(orig, int'(kk));
        k        = kk;
        in_last  = ($urandom_range(0, 7) == 0);
        in_valid = 1'b1;
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      step();
      cyc++;
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (5) step();
    check("t4_words_sent", 64'(sent), 64'd10000);
    check("t4_drained", 64'(exp_bits_q.size()), 64'd0);
    check("t4_word_cnt", 64'(word_cnt), 64'(exp_words[CW-1:0]));
    check("t4_frame_cnt", 64'(frame_cnt), 64'(exp_frames[CW-1:0]));

    // Reset with both stages full
    out_ready = 1'b0;
    in_valid = 1'b1; in_bits = {$urandom, $urandom}; k = 3'd2; in_last = 1'b1;
    step();
    in_bits = {$urandom, $urandom};
    step();
    check("t6_full_valid", {63'd0, out_valid}, 64'd1);
    check("t6_full_in_ready", {63'd0, in_ready}, 64'd0);
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    step();
    check("t6_rst_valid", {63'd0, out_valid}, 64'd0);
    check("t6_rst_bits", out_bits, 64'd0);
    check("t6_rst_word_cnt", 64'(word_cnt), 64'd0);
    check("t6_rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("t6_rst_frame_done", {63'd0, frame_done}, 64'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    check("t6_in_ready", {63'd0, in_ready}, 64'd1);
`ifndef PHASE3B_DEROT_AUTOKEY_EN
    r = {$urandom, $urandom};
    in_valid = 1'b1; in_bits = r; k = 3'd5;
    step();
    in_valid = 1'b0;
    check("t6_lat1_valid", {63'd0, out_valid}, 64'd0);
    step();
    check("t6_lat2_valid", {63'd0, out_valid}, 64'd1);
    check("t6_lat2_bits", out_bits, derot(r, 5));
    step();
`else
    in_valid = 1'b1; in_bits = 64'h0000_0000_0000_0001; k = 3'd0;
    step();
    step();
    check("t6_auto_k6", out_bits, 64'h0400_0000_0000_0000);
    step();
    check("t6_auto_k7", out_bits, 64'h0200_0000_0000_0000);
    step();
    in_valid = 1'b0;
    check("t6_auto_k0", out_bits, 64'h0000_0000_0000_0001);
    step();
    check("t6_auto_k1", out_bits, 64'h8000_0000_0000_0000);
    step();
`endif
    repeat (3) step();
    check("t6_word_cnt", 64'(word_cnt), 64'(exp_words[CW-1:0]));
    check("t6_drained", 64'(exp_bits_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/phase_3b_derotate_stream.md
Name: phase_3b_derotate_stream

Overview:
- Receive-side inverse of the phase-3b bit rotation.
- Takes a stream of BITSTREAM-bit words, each tagged with its 3-bit key k.
- Undoes the left rotation by k, producing a right rotation by k.
- Emits words through a 2-stage elastic valid/ready pipeline. Sits between the phase-3b channel output and the downstream decoder, and counts delivered words and frames.

Parameters:
- BITSTREAM, 64, word width in bits; must be >= 8.
- CNT_W, 16, width of word_cnt and frame_cnt.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  input word valid
- in_ready  output  1  block can accept a word this cycle
- in_bits  input  BITSTREAM  rotated word
- k  input  3  rotation key used by the forward rotation (ignored when PHASE3B_DEROT_AUTOKEY_EN is defined)
- in_last  input  1  word is the last of a frame
- out_valid  output  1  output word valid
- out_ready  input  1  downstream accepts
- out_bits  output  BITSTREAM  restored word
- out_last  output  1  in_last delayed with the word
- word_cnt  output  CNT_W  words delivered, wraps at 2^CNT_W
- frame_cnt  output  CNT_W  frames delivered (out_last handshakes), wraps
- frame_done  output  1  one-cycle pulse on the cycle after an out_last handshake

Behaviour:
- Transfer rule: a transfer occurs when valid && ready is high at a rising clk edge.
- Function: out_bits[i] = in_bits[(i + k) mod BITSTREAM]. Applying the forward phase-3b rotation with the same k to out_bits reproduces in_bits.
- Stage 1 (S1) register:
  - Captures in_bits right-rotated by 4·k[2] + 2·k[1].
  - Also captures k[0], in_last, and valid v1.
- Stage 2 (S2) register:
  - Captures the S1 data right-rotated by k[0].
  - Also captures last and valid v2.
  - S2 drives out_* directly.
- Latency: 2 cycles from input handshake to out_valid, with no stalls.
- Throughput: 1 word/cycle.
- Elasticity:
  - ready2 = !v2 || out_ready
  - ready1 = !v1 || ready2
  - in_ready = ready1, purely combinational from the registers and out_ready.
- Data and last in a stage hold stable while valid is high and the downstream stage is not ready.
- out_valid is never retracted before its handshake.
- Simultaneous events:
  - S1 may load a new word in the same cycle S1 hands off to S2.
  - S2 may load in the same cycle it hands off downstream.
- Counters:
  - word_cnt increments on every out_valid && out_ready.
  - frame_cnt increments when that handshake also has out_last = 1.
  - Both wrap from 2^CNT_W−1 to 0.
- frame_done is registered: 1 for exactly one cycle following an out_last handshake.
- Reset (rst_n low at a clk edge, including mid-stream):
  - v1 = v2 = 0, out_valid = 0, out_last = 0, out_bits = 0.
  - word_cnt = 0, frame_cnt = 0, frame_done = 0.
  - in_ready is 1 on the first cycle after reset is released.
  - In-flight words are discarded.
- k = 0 passes data unchanged. k = 7 right-rotates by 7.

Optional Feature:
- Macro: PHASE3B_DEROT_AUTOKEY_EN.
- Defined:
  - Adds input port key_seed (3 bits).
  - An internal 3-bit key register loads key_seed on reset.
  - The key register increments (mod 8) on every input handshake.
  - It reloads key_seed after an input handshake with in_last = 1.
  - Port k is ignored; each word uses the key register's value at its input handshake.
- Undefined: the per-word k port is used, no key register exists, and there is no key_seed port.

Decomposition:
- Package phase3b_pkg:
  - localparam KEY_W = 3.
  - Default BITSTREAM = 64.
  - typedef logic [KEY_W-1:0] phase3b_key_t.
- Sub-module: phase3b_rotr_stage.
  - Parameterised combinational right-rotate by a constant amount when enabled.
  - Instantiated three times (amounts 4, 2, 1) across the two stages.

Test Plan:
1. Reset, then in_bits = 64'h0000_0000_0000_0001, k = 3, out_ready = 1 -> out_bits = 64'h2000_0000_0000_0000 two cycles later; word_cnt = 1.
2. Back-to-back words 64'h8000_0000_0000_0000 with k = 1, 2, 4, 7 -> 64'h4000_0000_0000_0000, 64'h2000_0000_0000_0000, 64'h0800_0000_0000_0000, 64'h0100_0000_0000_0000 on four consecutive cycles.
3. out_ready held low 5 cycles with the stream pending:
   - in_ready drops after 2 words accepted.
   - out_bits and out_last stay stable.
   - No words are lost or duplicated after release.
4. Random words and k with random out_ready, 10k words -> output equals the forward-rotated input unrotated, in order, verified against a reference model; word_cnt matches.
5. Frame of 3 words, third with in_last = 1 -> out_last on the third output; frame_done high exactly 1 cycle later; frame_cnt = 1.
6. rst_n asserted with both stages full -> out_valid = 0 and counters = 0 at the next edge; a word sent after release emerges with 2-cycle latency. With PHASE3B_DEROT_AUTOKEY_EN defined and key_seed = 6, words use k = 6, 7, 0, 1.
